// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//
// Byte buffer and launch controller that sits directly in front of the UART
// transmitter. System-side writes land in a small circular FIFO. The launch
// FSM hands the words to the transmitter one at a time and paces them from
// the transmitter's busy flag.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   wr_en/wr_data  push request and word
//   full/empty     FIFO occupancy flags (registered)
//   fill_count     FIFO occupancy, 0..FIFO_DEPTH (registered)
//   overflow       one-cycle pulse: a push was dropped because the FIFO was full
//   tx_busy        busy flag from the transmitter (already registered there)
//   tx_data_valid  one-cycle launch pulse to the transmitter
//   tx_p_data      launched word, held until the next launch
//   tx_timeout     one-cycle pulse: busy never rose after a launch
//
// Launch handshake: tx_data_valid is a single-cycle strobe. It is only
// raised from IDLE while tx_busy is sampled low. The transmitter
// acknowledges it by raising tx_busy for the length of the frame. If busy
// does not rise within BUSY_TIMEOUT cycles, the launched word is abandoned
// and not retried.

module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_count,
    output logic                          overflow,
    input  logic                          tx_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [TW-1:0]         to_cnt;
    logic [TW-1:0]         to_cnt_next;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  timeout_hit;
    logic [CW-1:0]         count_next;

    // Launch FSM: next state, pop request and timeout counter.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        to_cnt_next = to_cnt;
        case (state)
            IDLE: begin
                // The empty flag is registered, so a word written into an
                // empty FIFO is launched one edge after it is stored.
                if (!empty && !tx_busy) begin
                    pop         = 1'b1;
                    to_cnt_next = '0;
                    state_next  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                to_cnt_next = to_cnt + 1'b1;
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the same edge pops the head.
    always_comb begin
        push       = wr_en && (!full || pop);
        drop       = wr_en && full && !pop;
        count_next = fill_count;
        case ({push, pop})
            2'b10:   count_next = fill_count + 1'b1;
            2'b01:   count_next = fill_count - 1'b1;
            default: count_next = fill_count;
        endcase
    end

    // Storage carries no reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            to_cnt        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_count    <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            tx_timeout    <= 1'b0;
        end else begin
            state         <= state_next;
            to_cnt        <= to_cnt_next;
            fill_count    <= count_next;
            full          <= (count_next == DEPTH_C);
            empty         <= (count_next == '0);
            overflow      <= drop;
            tx_data_valid <= pop;
            tx_timeout    <= timeout_hit;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                // When full, a simultaneous push targets this same slot; the
                // read here still sees the old head.
                tx_p_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder.
// Inputs are driven on the falling edge. Outputs are checked 1 time unit
// after each rising edge against a reference model built from a word queue
// and a "transmitter free" flag. A behavioural transmitter raises busy two
// cycles after it sees a launch.

module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic          empty;
    logic [3:0]    fill_count;
    logic          overflow;
    logic          tx_busy;
    logic          tx_data_valid;
    logic [DW-1:0] tx_p_data;
    logic          tx_timeout;

    logic busy_model = 1'b0;
    logic busy_force = 1'b0;
    logic tx_silent  = 1'b0;
    int   busy_len   = 10;

    assign tx_busy = busy_model | busy_force;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_feeder #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .tx_busy      (tx_busy),
        .tx_data_valid(tx_data_valid),
        .tx_p_data    (tx_p_data),
        .tx_timeout   (tx_timeout)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model ----------------
    int dly  = 0;
    int hold = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy_model = 1'b0;
            dly        = 0;
            hold       = 0;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) busy_model = 1'b0;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                busy_model = 1'b1;
                hold       = busy_len;
            end
        end else if (tx_data_valid && !tx_silent) begin
            dly = 2;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    bit            xmit_free = 1'b1;
    bit            seen_busy = 1'b0;
    int            since     = 0;
    logic [DW-1:0] last_word = '0;

    always @(posedge clk) begin
        bit e_launch, e_accept, e_ovf, e_to;
        #1;
        if (!reset) begin
            exp_q.delete();
            xmit_free = 1'b1;
            seen_busy = 1'b0;
            since     = 0;
            last_word = '0;
            check("rst_valid", tx_data_valid, 0);
            check("rst_pdata", tx_p_data, 0);
            check("rst_fill", fill_count, 0);
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_ovf", overflow, 0);
            check("rst_tmo", tx_timeout, 0);
        end else begin
            // The feeder launches when the transmitter is free, a word is
            // waiting, and busy is low. Writes landing this edge are not yet
            // visible to the launch decision.
            e_launch = xmit_free && (exp_q.size() > 0) && !tx_busy;
            e_accept = wr_en && ((exp_q.size() < DEPTH) || e_launch);
            e_ovf    = wr_en && !e_accept;
            e_to     = 1'b0;
            if (xmit_free) begin
                if (e_launch) begin
                    xmit_free = 1'b0;
                    seen_busy = 1'b0;
                    since     = 0;
                    last_word = exp_q.pop_front();
                end
            end else if (!seen_busy) begin
                since++;
                if (tx_busy) begin
                    seen_busy = 1'b1;
                end else if (since == TMO) begin
                    e_to      = 1'b1;
                    xmit_free = 1'b1;
                end
            end else if (!tx_busy) begin
                xmit_free = 1'b1;
            end
            if (e_accept) exp_q.push_back(wr_data);

            check("tx_valid", tx_data_valid, e_launch);
            check("tx_p_data", tx_p_data, last_word);
            check("overflow", overflow, e_ovf);
            check("tx_timeout", tx_timeout, e_to);
            check("fill_count", fill_count, exp_q.size());
            check("full", full, exp_q.size() == DEPTH);
            check("empty", empty, exp_q.size() == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;

        reset = 1'b0;
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Single word through an idle transmitter.
        busy_len = 10;
        push(8'hA5);
        idle(20);

        // Burst into a busy transmitter, ninth word dropped.
        busy_force = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            d = 8'(i);
            push(d);
        end
        idle(2);
        busy_force = 1'b0;
        busy_len   = 4;
        idle(110);

        // Full FIFO: push on the same edge as a launch pop.
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'h21 + 8'(i);
            push(d);
        end
        @(negedge clk);
        busy_force = 1'b0;
        wr_en      = 1'b1;
        wr_data    = 8'h99;
        idle(110);

        // Transmitter never answers: both words time out.
        tx_silent = 1'b1;
        push(8'h31);
        push(8'h32);
        idle(30);
        tx_silent = 1'b0;
        idle(5);

        // Reset in the middle of a frame with three words queued.
        busy_len = 20;
        for (int i = 0; i < 4; i++) begin
            d = 8'h41 + 8'(i);
            push(d);
        end
        idle(8);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_fill", fill_count, 0);
        check("async_empty", empty, 1);
        check("async_full", full, 0);
        check("async_valid", tx_data_valid, 0);
        check("async_pdata", tx_p_data, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        idle(10);
        push(8'h55);
        idle(25);

        // Pointer wrap: 20 single push/launch rounds.
        busy_len = 2;
        for (int i = 0; i < 20; i++) begin
            d = 8'h10 + 8'(i);
            push(d);
            idle(7);
        end

        // Random traffic with random frame lengths and occasional silence.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            wr_en     = ($urandom_range(0, 99) < 45);
            wr_data   = 8'($urandom);
            busy_len  = $urandom_range(1, 6);
            tx_silent = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        wr_en     = 1'b0;
        tx_silent = 1'b0;
        idle(200);

        check("drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and launch controller directly upstream of the UART transmitter. Accepts parallel words from the system side into a small synchronous FIFO. Presents them one at a time to the transmitter as a single-cycle valid pulse with held data. Paces launches from the transmitter's busy flag, so producers can burst writes without tracking frame timing.

## Interface
- DATA_WIDTH, 8, width of each word and of tx_p_data
- FIFO_DEPTH, 8, number of FIFO entries; power of two, ≥ 2
- BUSY_TIMEOUT, 8, maximum cycles spent in WAIT_BUSY before abandoning a launch; ≥ 4

- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  push request
- wr_data  in  DATA_WIDTH  word to push
- full  out  1  FIFO holds FIFO_DEPTH words
- empty  out  1  FIFO holds 0 words
- fill_count  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse when a push is dropped
- tx_busy  in  1  transmitter busy flag (registered in the transmitter)
- tx_data_valid  out  1  one-cycle launch pulse to transmitter
- tx_p_data  out  DATA_WIDTH  word being transmitted; held from launch until the next launch
- tx_timeout  out  1  one-cycle pulse when busy never rose after a launch

## Operation
- FIFO: circular buffer, read/write pointers clog2(FIFO_DEPTH) bits wrapping modulo depth, and a separate occupancy counter. full = (count == FIFO_DEPTH). empty = (count == 0).
- Push: wr_en && (!full || pop_this_cycle) → store wr_data at the write pointer and advance it. wr_en && full && !pop → word dropped, overflow = 1 next cycle, no state change.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full.
- No fall-through: a word pushed into an empty FIFO is launched no earlier than the cycle after it is written.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty && !tx_busy, at the edge: tx_p_data ← head word, tx_data_valid ← 1, pop (read pointer +1, count −1), timeout counter ← 0, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: tx_data_valid ← 0 at the first edge. The timeout counter increments each cycle.
    - tx_busy == 1 → WAIT_DONE.
    - Counter reaches BUSY_TIMEOUT−1 with tx_busy still 0 → tx_timeout pulse, go to IDLE. The popped word is not retried.
  - WAIT_DONE: stay while tx_busy == 1. tx_busy == 0 → IDLE.
- tx_p_data changes only on a launch edge. It is stable during the entire frame.
- Writes continue to be accepted in every state.

## Timing
- Reset values: full 0, empty 1, fill_count 0, overflow 0, tx_data_valid 0, tx_p_data 0, tx_timeout 0, state IDLE, pointers 0. FIFO contents are don't-care.
- Reset asserted mid-frame: FIFO flushed, launch abandoned, and all outputs at reset values immediately (asynchronous).
- All outputs are registered. full, empty and fill_count update on the edge after the push/pop.
- Push-to-launch latency with the FIFO empty and the transmitter idle:
  - wr_en sampled at edge N.
  - tx_data_valid is high during cycle N+1 → N+2.
- Transmitter response:
  - It samples valid at N+2.
  - tx_busy rises after N+3.
  - The feeder enters WAIT_DONE at edge N+4. This is within the default timeout.
- Back-to-back frames: after tx_busy falls, the feeder is back in IDLE one edge later and launches on the following edge if the FIFO is non-empty. The minimum gap is 2 cycles from the tx_busy fall to the next tx_data_valid.
- tx_data_valid is never high for more than one consecutive cycle. It is never asserted while tx_busy == 1 is sampled in IDLE.
- overflow and tx_timeout are single-cycle pulses and never sticky.

## Test plan
- Reset then single write 0xA5 at edge N, transmitter model raises busy 2 cycles after valid for 10 cycles → tx_data_valid high exactly one cycle starting after N+1, tx_p_data = 0xA5 held until the next launch, empty returns to 1 after the pop edge.
- Burst of 8 writes (0x01..0x08) at depth 8 while the transmitter is busy → full = 1 and fill_count = 8. A 9th write gives an overflow pulse and is dropped. Launches then occur in order 0x01..0x08, each only after the previous busy fall.
- FIFO full with a push and a launch pop in the same cycle → no overflow, fill_count stays 8, the new word is transmitted last.
- Transmitter model never raises tx_busy → tx_timeout pulses BUSY_TIMEOUT cycles after the launch, the FSM returns to IDLE, and the next queued word launches.
- Reset asserted in WAIT_DONE with 3 words queued → fill_count 0, empty 1, tx_data_valid 0 immediately. No launch occurs after release until a new write arrives.
- Write pointer wrap: 20 push/pop cycles at depth 8 with pattern 0x10+i → transmitted sequence matches exactly with no duplication or loss.
